// File: rtl/cat_tx_pkg.sv
// Shared types and helpers for the AD9361 TX sample feeder.
// Holds the feeder state encoding, per-lane sample structs and the 16->12 bit rounder.
package cat_tx_pkg;

    localparam int SAMP_W    = 12;
    localparam int AXI_W     = 32;
    localparam int COMP_W    = AXI_W / 2;
    localparam int NUM_LANES = 2;

    localparam logic [COMP_W-1:0] SAT_THRESH = 16'h7FF8;
    localparam logic [SAMP_W-1:0] SAT_MAX    = 12'h7FF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRIME    = 2'd1,
        RUN      = 2'd2,
        UNDERRUN = 2'd3
    } tx_state_e;

    typedef struct packed {
        logic [COMP_W-1:0] i;
        logic [COMP_W-1:0] q;
    } axi_samp_t;

    typedef struct packed {
        logic [SAMP_W-1:0] i;
        logic [SAMP_W-1:0] q;
    } tx_samp_t;

    // Round half-up by adding 8 LSBs; only the positive end can overflow 12 bits.
    function automatic logic [SAMP_W-1:0] round_sat(input logic [COMP_W-1:0] x);
        logic [COMP_W:0] y;
        y = {x[COMP_W-1], x} + (COMP_W+1)'(8);
        if (!x[COMP_W-1] && (x >= SAT_THRESH))
            round_sat = SAT_MAX;
        else
            round_sat = SAMP_W'(y >> 4);
    endfunction

endpackage

// File: rtl/cat_tx_fifo.sv
// First-word-fall-through FIFO for one feeder channel.
// Head word is valid whenever !empty; flush clears occupancy on the next edge.
module cat_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                       radio_clk,
    input  logic                       radio_rst,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign push    = wr_en && !full && !flush;
    assign pop     = rd_en && !empty && !flush;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge radio_clk or posedge radio_rst) begin
        if (radio_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge radio_clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/cat_tx_feeder.sv
// Two-channel TX sample feeder: per-channel FWFT buffering, priming, underrun
// detection and lock-step pops so both channels stay sample-aligned.
module cat_tx_feeder
    import cat_tx_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int PRIME_LEVEL = 4
) (
    input  logic              radio_clk,
    input  logic              radio_rst,
    input  logic              run,
    input  logic [1:0]        ch_en,
    input  logic [AXI_W-1:0]  s0_tdata,
    input  logic              s0_tvalid,
    output logic              s0_tready,
    input  logic [AXI_W-1:0]  s1_tdata,
    input  logic              s1_tvalid,
    output logic              s1_tready,
    input  logic              tx_stb,
    output logic [SAMP_W-1:0] tx_i0,
    output logic [SAMP_W-1:0] tx_q0,
    output logic [SAMP_W-1:0] tx_i1,
    output logic [SAMP_W-1:0] tx_q1,
    output logic              underrun,
    output logic [15:0]       underrun_cnt,
    output logic              active
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e state;
    tx_state_e state_nxt;

    logic [NUM_LANES-1:0]         en_q;
    logic [NUM_LANES-1:0]         s_tvalid;
    logic [NUM_LANES-1:0]         s_tready;
    logic [NUM_LANES-1:0]         fifo_full;
    logic [NUM_LANES-1:0]         fifo_empty;
    logic [NUM_LANES-1:0]         ch_primed;
    logic [NUM_LANES-1:0]         ch_starved;
    logic [NUM_LANES-1:0][LW-1:0] level;
    axi_samp_t [NUM_LANES-1:0]    s_tdata;
    axi_samp_t [NUM_LANES-1:0]    head;
    tx_samp_t  [NUM_LANES-1:0]    tx_d;
    tx_samp_t  [NUM_LANES-1:0]    tx_q;

    logic accept;
    logic flush;
    logic stb_run;
    logic pop;
    logic ur_hit;

    assign s_tdata   = {s1_tdata, s0_tdata};
    assign s_tvalid  = {s1_tvalid, s0_tvalid};
    assign s0_tready = s_tready[0];
    assign s1_tready = s_tready[1];

    // A dropped run request wins over every other event this cycle.
    assign flush   = (state == IDLE) || !run;
    assign stb_run = (state == RUN) && run && tx_stb;
    assign pop     = stb_run && !(|ch_starved);
    assign ur_hit  = stb_run && (|ch_starved);

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_ch
        assign s_tready[n]   = accept && en_q[n] && !fifo_full[n];
        assign ch_primed[n]  = !en_q[n] || (level[n] >= LW'(PRIME_LEVEL));
        assign ch_starved[n] = en_q[n] && fifo_empty[n];
        assign tx_d[n]       = en_q[n] ? '{i: round_sat(head[n].i), q: round_sat(head[n].q)}
                                       : '0;

        cat_tx_fifo #(
            .DEPTH (FIFO_DEPTH),
            .W     (AXI_W)
        ) u_fifo (
            .radio_clk (radio_clk),
            .radio_rst (radio_rst),
            .flush     (flush),
            .wr_en     (s_tvalid[n] && s_tready[n]),
            .wr_data   (s_tdata[n]),
            .rd_en     (pop && en_q[n]),
            .rd_data   (head[n]),
            .full      (fifo_full[n]),
            .empty     (fifo_empty[n]),
            .level     (level[n])
        );
    end

    always_ff @(posedge radio_clk or posedge radio_rst) begin
        if (radio_rst) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!run) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:     if (|ch_en)                state_nxt = PRIME;
                PRIME:    if (&ch_primed)            state_nxt = RUN;
                RUN:      if (tx_stb && |ch_starved) state_nxt = UNDERRUN;
                UNDERRUN: state_nxt = UNDERRUN;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        accept = 1'b0;
        active = 1'b0;
        case (state)
            PRIME:    accept = 1'b1;
            RUN:      begin accept = 1'b1; active = 1'b1; end
            UNDERRUN: accept = 1'b1;
            default:  ;
        endcase
    end

    // Channel mask is frozen for the whole transmit session.
    always_ff @(posedge radio_clk or posedge radio_rst) begin
        if (radio_rst)
            en_q <= '0;
        else if ((state == IDLE) && run && (|ch_en))
            en_q <= ch_en;
    end

    always_ff @(posedge radio_clk or posedge radio_rst) begin
        if (radio_rst) begin
            tx_q         <= '0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            underrun <= ur_hit;
            if (ur_hit && (underrun_cnt != 16'hFFFF))
                underrun_cnt <= underrun_cnt + 1'b1;
            if (!run || ur_hit)
                tx_q <= '0;
            else if (pop)
                tx_q <= tx_d;
        end
    end

    assign tx_i0 = tx_q[0].i;
    assign tx_q0 = tx_q[0].q;
    assign tx_i1 = tx_q[1].i;
    assign tx_q1 = tx_q[1].q;

endmodule

// File: doc/cat_tx_feeder.md
# cat_tx_feeder

TX sample feeder that sits directly upstream of the AD9361 CMOS IO block, on the `radio_clk` domain. It accepts two 16-bit I/Q AXI-Stream channels and buffers each in a small FIFO. It rounds and saturates samples to 12 bits and presents them on `tx_i0/tx_q0/tx_i1/tx_q1`, one sample per channel per `tx_stb` from the IO block. It also primes before transmit, detects underrun, and keeps both channels sample-aligned.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: per-channel FIFO depth, power of 2, minimum 4.
- `PRIME_LEVEL`, default 4: per-channel occupancy required before leaving PRIME; range 1..`FIFO_DEPTH`.

Ports. Reset `radio_rst`, asynchronous, active-high; clock `radio_clk`.
- `radio_clk`  in  1  sample clock
- `radio_rst`  in  1  async active-high reset
- `run`  in  1  level; 1 = transmit requested
- `ch_en`  in  2  channel enables, bit n = channel n
- `s0_tdata` / `s1_tdata`  in  32  [31:16] I, [15:0] Q, two's complement
- `s0_tvalid` / `s1_tvalid`  in  1  AXI-Stream valid
- `s0_tready` / `s1_tready`  out  1  AXI-Stream ready
- `tx_stb`  in  1  sample request pulse from the IO block
- `tx_i0`, `tx_q0`, `tx_i1`, `tx_q1`  out  12  registered samples to the IO block
- `underrun`  out  1  one-cycle pulse on underrun entry
- `underrun_cnt`  out  16  saturating underrun count, cleared by reset only
- `active`  out  1  1 while in RUN

## Operation
- States:
  - IDLE: FIFOs held flushed; `sN_tready` = 0; outputs = 0.
  - PRIME: FIFOs fill.
  - RUN: samples popped on `tx_stb`.
  - UNDERRUN: outputs forced to 0; no pops.
- Transitions:
  - IDLE→PRIME when `run`=1 and `ch_en`≠0.
  - PRIME→RUN when every enabled channel has occupancy ≥ `PRIME_LEVEL`.
  - RUN→UNDERRUN on a `tx_stb` where any enabled FIFO is empty.
  - Any state→IDLE when `run`=0. This has priority over all other transitions.
  - UNDERRUN is left only through IDLE.
- FIFO write: `sN_tready` = state≠IDLE & `ch_en[n]` & !full. Write happens on tvalid&tready.
- Disabled channel: `sN_tready` = 0; its outputs are 0; it is ignored in the prime and underrun checks.
- Pop: in RUN on `tx_stb`, all enabled FIFOs pop together, and only if all of them are non-empty. There are never partial pops, which guarantees channel alignment.
- Rounding, applied per 16-bit component x (17-bit intermediate):
  - y = x + 8.
  - If x ≥ 0x7FF8 (positive), result = 0x7FF.
  - Else result = y[15:4].
  - Negative values never saturate.
- `underrun_cnt` saturates at 0xFFFF.
- `ch_en` changes are honoured only in IDLE; the value is sampled on the IDLE→PRIME transition.

## Timing
- Reset values: all outputs 0; state IDLE; FIFOs empty.
- `tx_stb` at cycle t with a pop: `tx_*` registered at edge t+1 and held until the next update.
- The IO block samples `tx_*` on its next `tx_stb`, so the feeder adds exactly one stage of latency.
- Underrun `tx_stb` at t: `underrun`=1 during cycle t+1; `tx_*` = 0 from t+1.
- FIFO is first-word-fall-through. A write at t is visible for pop at t+1, and occupancy updates at t+1.
- Simultaneous write and pop when full: the pop frees the slot, but tready is computed from the current (full) state, so the write does not occur.
- Simultaneous write and pop when empty in RUN: this counts as underrun; the written word is kept.
- `run` falling mid-burst: IDLE on the next edge; FIFOs flushed; outputs 0 the next cycle.
- Reset asserted mid-operation: immediate asynchronous return to reset values.

## Structure
- Package `cat_tx_pkg`:
  - state enum {IDLE, PRIME, RUN, UNDERRUN}
  - `SAMP_W`=12, `AXI_W`=32
  - round/saturate function.
- Sub-module `cat_tx_fifo`: synchronous FWFT FIFO with `flush`, `full`, `empty`, `level`; instantiated twice.
- Top: FSM, pop/alignment logic, rounding, output registers, counter.

## Test plan
- Prime and stream: `ch_en`=2'b11, PRIME_LEVEL=4. Write 4 words per channel, with s0 = 0x0010_FFF0, then `tx_stb` every 2 cycles. Required: `active` rises. First `tx_i0`=0x001, `tx_q0`=0xFFF, one cycle after the first stb.
- Rounding/saturation:
  - I=0x7FF8 → 0x7FF
  - I=0x7FF7 → 0x7FF
  - I=0x8000 → 0x800
  - I=0x0007 → 0x000
  - I=0x0008 → 0x001
- Underrun: stop feeding s1 while s0 still holds data. Required: on the next `tx_stb`, `underrun` pulses once and `underrun_cnt`=1. All `tx_*`=0, and s0 is not popped, so its level is unchanged.
- SISO: `ch_en`=2'b01, s1_tvalid=0. Required: RUN is reached with only s0 primed; `s1_tready`=0; `tx_i1`/`tx_q1` stay 0.
- Run drop: deassert `run` mid-RUN with both FIFOs at 3 words. Required: IDLE next cycle; tready=0; both levels 0; outputs 0. Re-asserting `run` re-primes from empty.
- Backpressure: FIFO_DEPTH=8 with no `tx_stb`. Required: `s0_tready` falls after 8 accepted words, and there is no write while full.
